// File: rtl/lif_pkg.sv
// lif_pkg: shared FSM encoding, default layer parameters and the
// saturation helper used by the leaky-integrate-and-fire scheduler.
package lif_pkg;

  // Scheduler FSM encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lif_fsm_e;

  // Default layer configuration.
  localparam int LIF_N_NEURONS    = 4;
  localparam int LIF_STATE_W      = 8;
  localparam int LIF_THRESHOLD    = 200;
  localparam int LIF_DECAY_SHIFT  = 1;
  localparam int LIF_REFRAC_STEPS = 2;

  // Clamp an unsigned sum to the largest value representable in 'width' bits.
  function automatic logic [31:0] saturate(input logic [31:0] sum,
                                           input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/lif_update.sv
// lif_update: combinational single-neuron LIF step.
// Leak by right shift, integrate the input current with saturation, compare
// against the threshold, and manage the refractory count.  With
// REFRAC_STEPS=0 the refractory path collapses to constant zero.
module lif_update
  import lif_pkg::*;
#(
  parameter int STATE_W      = LIF_STATE_W,
  parameter int THRESHOLD    = LIF_THRESHOLD,
  parameter int DECAY_SHIFT  = LIF_DECAY_SHIFT,
  parameter int REFRAC_STEPS = 0,
  parameter int REF_W        = 1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [STATE_W-1:0] cur,
  input  logic [REF_W-1:0]   ref_cnt,
  output logic [STATE_W-1:0] state_nxt,
  output logic               spike,
  output logic [REF_W-1:0]   ref_nxt
);

  logic [STATE_W:0]   sum;
  logic [STATE_W-1:0] sat;
  logic               fire;

  // One extra bit keeps the carry so saturation can see the overflow.
  assign sum  = {1'b0, state >> DECAY_SHIFT} + {1'b0, cur};
  assign sat  = STATE_W'(saturate(32'(sum), STATE_W));
  assign fire = (32'(sat) >= 32'(THRESHOLD));

  // Refractory neurons are clamped silent; otherwise fire-and-reset or integrate.
  always_comb begin
    state_nxt = sat;
    spike     = 1'b0;
    ref_nxt   = '0;
    if (REFRAC_STEPS > 0 && ref_cnt != '0) begin
      state_nxt = '0;
      ref_nxt   = ref_cnt - REF_W'(1);
    end else if (fire) begin
      state_nxt = '0;
      spike     = 1'b1;
      ref_nxt   = REF_W'(REFRAC_STEPS);
    end
  end

endmodule

// File: rtl/lif_sched.sv
// lif_sched: time-multiplexed LIF layer scheduler.
// A step request walks neurons 0..N_NEURONS-1, one per cycle, through a single
// lif_update engine, then publishes the spike vector with a one-cycle done.
// Optional feature: define LIF_SCHED_REFRAC_EN to add per-neuron refractory
// counters of REFRAC_STEPS timesteps.
module lif_sched
  import lif_pkg::*;
#(
  parameter int N_NEURONS    = LIF_N_NEURONS,
  parameter int STATE_W      = LIF_STATE_W,
  parameter int THRESHOLD    = LIF_THRESHOLD,
  parameter int DECAY_SHIFT  = LIF_DECAY_SHIFT,
  parameter int REFRAC_STEPS = LIF_REFRAC_STEPS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step,
  output logic                         busy,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic [STATE_W-1:0]           cur_in,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic                         done,
  input  logic [$clog2(N_NEURONS)-1:0] mon_sel,
  output logic [STATE_W-1:0]           mon_state
);

  localparam int IDX_W = $clog2(N_NEURONS);
  localparam int REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;
`ifdef LIF_SCHED_REFRAC_EN
  localparam int UPD_REFRAC = REFRAC_STEPS;
`else
  localparam int UPD_REFRAC = 0;
`endif

  localparam logic [1:0]       ST_IDLE  = IDLE;
  localparam logic [1:0]       ST_RUN   = RUN;
  localparam logic [1:0]       ST_DONE  = DONE;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  logic [1:0]           fsm_reg, fsm_next;
  logic [IDX_W-1:0]     idx_reg;
  logic [N_NEURONS-1:0] acc_reg, acc_next;
  logic [N_NEURONS-1:0] spike_vec_reg;
  logic [STATE_W-1:0]   state_mem [N_NEURONS];
  logic [STATE_W-1:0]   upd_state;
  logic [STATE_W-1:0]   upd_state_nxt;
  logic                 upd_spike;
  logic [REF_W-1:0]     ref_cur;
  logic [REF_W-1:0]     ref_nxt;
  logic                 run_active;

  assign run_active = (fsm_reg == ST_RUN);
  assign upd_state  = state_mem[idx_reg];

`ifdef LIF_SCHED_REFRAC_EN
  logic [REF_W-1:0] ref_mem [N_NEURONS];
  assign ref_cur = ref_mem[idx_reg];
`else
  assign ref_cur = '0;
`endif

  lif_update #(
    .STATE_W      (STATE_W),
    .THRESHOLD    (THRESHOLD),
    .DECAY_SHIFT  (DECAY_SHIFT),
    .REFRAC_STEPS (UPD_REFRAC),
    .REF_W        (REF_W)
  ) u_update (
    .state     (upd_state),
    .cur       (cur_in),
    .ref_cnt   (ref_cur),
    .state_nxt (upd_state_nxt),
    .spike     (upd_spike),
    .ref_nxt   (ref_nxt)
  );

  // Spike accumulator including the neuron being updated this cycle.
  assign acc_next = acc_reg | (N_NEURONS'(upd_spike) << idx_reg);

  // Next-state logic: IDLE waits for step, RUN sweeps all neurons, DONE lasts one cycle.
  always_comb begin
    fsm_next = fsm_reg;
    case (fsm_reg)
      ST_IDLE: if (step) fsm_next = ST_RUN;
      ST_RUN:  if (idx_reg == LAST_IDX) fsm_next = ST_DONE;
      ST_DONE: fsm_next = ST_IDLE;
      default: fsm_next = ST_IDLE;
    endcase
  end

  // FSM, neuron index, spike accumulator and published spike vector.
  // spike_vec is loaded on the edge that enters DONE so it is already valid
  // in the cycle where done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= ST_IDLE;
      idx_reg       <= '0;
      acc_reg       <= '0;
      spike_vec_reg <= '0;
    end else begin
      fsm_reg <= fsm_next;
      case (fsm_reg)
        ST_IDLE: begin
          if (step) begin
            idx_reg <= '0;
            acc_reg <= '0;
          end
        end
        ST_RUN: begin
          acc_reg <= acc_next;
          if (idx_reg == LAST_IDX) begin
            idx_reg       <= '0;
            spike_vec_reg <= acc_next;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Per-neuron membrane (and refractory) storage; written only on its RUN slot.
  for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_neuron
    logic wr_en;
    assign wr_en = run_active && (idx_reg == IDX_W'(gi));

    // Membrane state register for neuron gi.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_mem[gi] <= '0;
      end else if (wr_en) begin
        state_mem[gi] <= upd_state_nxt;
      end
    end

`ifdef LIF_SCHED_REFRAC_EN
    // Refractory countdown register for neuron gi.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ref_mem[gi] <= '0;
      end else if (wr_en) begin
        ref_mem[gi] <= ref_nxt;
      end
    end
`endif
  end

`ifndef LIF_SCHED_REFRAC_EN
  // Without refractory storage the engine's count output has no consumer.
  logic ref_nxt_unused;
  assign ref_nxt_unused = ^ref_nxt;
`endif

  assign busy      = (fsm_reg != ST_IDLE);
  assign done      = (fsm_reg == ST_DONE);
  assign cur_idx   = run_active ? idx_reg : '0;
  assign spike_vec = spike_vec_reg;
  // Out-of-range selections (non power-of-two layers) read as zero.
  assign mon_state = (32'(mon_sel) < 32'(N_NEURONS)) ? state_mem[mon_sel] : '0;

endmodule

// File: tb/tb_lif_sched.sv
// tb_lif_sched: table-driven, scoreboard-checked bench for lif_sched.
// Honors LIF_SCHED_REFRAC_EN to select the refractory vector table.
module tb_lif_sched;
  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [N-1:0][W-1:0] cur;
    logic [N-1:0]        spk;
    logic [N-1:0][W-1:0] st;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         step;
  logic         busy;
  logic [1:0]   cur_idx;
  logic [W-1:0] cur_in;
  logic [N-1:0] spike_vec;
  logic         done;
  logic [1:0]   mon_sel;
  logic [W-1:0] mon_state;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   last_done = 0;
  int   prev_done = 0;
  vec_t sb_q[$];
  vec_t vecs[8];
  int   nv;

  lif_sched #(
    .N_NEURONS(N), .STATE_W(W), .THRESHOLD(200), .DECAY_SHIFT(1), .REFRAC_STEPS(2)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .busy(busy), .cur_idx(cur_idx),
    .cur_in(cur_in), .spike_vec(spike_vec), .done(done),
    .mon_sel(mon_sel), .mon_state(mon_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) begin
      done_cnt  <= done_cnt + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
  end

  function automatic vec_t mk(int c0, int c1, int c2, int c3, logic [N-1:0] spk,
                              int s0, int s1, int s2, int s3);
    vec_t v;
    v.cur[0] = W'(c0); v.cur[1] = W'(c1); v.cur[2] = W'(c2); v.cur[3] = W'(c3);
    v.spk = spk;
    v.st[0] = W'(s0); v.st[1] = W'(s1); v.st[2] = W'(s2); v.st[3] = W'(s3);
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_states(string tag, logic [N-1:0][W-1:0] st);
    for (int i = 0; i < N; i++) begin
      mon_sel = 2'(i);
      #1;
      chk($sformatf("%s_state%0d", tag, i), int'(mon_state), int'(st[i]));
    end
  endtask

  // Issue one timestep, feed currents by slot, compare at done against the scoreboard.
  task automatic do_step(vec_t v, string tag);
    int   k;
    bit   seen;
    vec_t e;
    @(posedge clk); #1;
    step = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    step = 1'b0;
    k = 0;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (done) begin
        seen = 1'b1;
        chk({tag, "_latency"}, c, N + 1);
        e = sb_q.pop_front();
        chk({tag, "_spike_vec"}, int'(spike_vec), int'(e.spk));
        check_states(tag, e.st);
        $display("step %s: latency=%0d spike_vec=%b", tag, c, spike_vec);
      end else begin
        chk($sformatf("%s_cur_idx%0d", tag, k), int'(cur_idx), k);
        cur_in = (k < N) ? v.cur[k] : '0;
        k++;
        @(posedge clk); #1;
      end
    end
    if (!seen) chk({tag, "_done_timeout"}, 0, 1);
    cur_in = '0;
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    if (seen) chk({tag, "_spike_hold"}, int'(spike_vec), int'(e.spk));
  endtask

  initial begin
    int base;
    rst = 1'b1; step = 1'b0; cur_in = '0; mon_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_spike_vec", int'(spike_vec), 0);
    chk("reset_cur_idx", int'(cur_idx), 0);
    check_states("reset", '0);

`ifdef LIF_SCHED_REFRAC_EN
    nv = 4;
    vecs[0] = mk(255, 255, 255, 255, 4'b1111,   0,   0,   0,   0);
    vecs[1] = mk(255, 255, 255, 255, 4'b0000,   0,   0,   0,   0);
    vecs[2] = mk(255, 255, 255, 255, 4'b0000,   0,   0,   0,   0);
    vecs[3] = mk(255, 255, 255, 255, 4'b1111,   0,   0,   0,   0);
`else
    nv = 8;
    vecs[0] = mk( 60,  60,  60,  60, 4'b0000,  60,  60,  60,  60);
    vecs[1] = mk( 60,  60,  60,  60, 4'b0000,  90,  90,  90,  90);
    vecs[2] = mk(  0,   0, 135,   0, 4'b0000,  45,  45, 180,  45);
    vecs[3] = mk(  0,   0, 120,   0, 4'b0100,  22,  22,   0,  22);
    vecs[4] = mk(255,   0, 255, 200, 4'b1101,   0,  11,   0,   0);
    vecs[5] = mk(199, 195, 199,   0, 4'b0010, 199,   0, 199,   0);
    vecs[6] = mk(101,   0, 100,   0, 4'b0001,   0,   0, 199,   0);
    vecs[7] = mk(  0,   0,   0,   0, 4'b0000,   0,   0,  99,   0);
`endif
    for (int i = 0; i < nv; i++) do_step(vecs[i], $sformatf("vec%0d", i));

    // Step pulsed mid-RUN is dropped: exactly one done.
    base = done_cnt;
    @(posedge clk); #1; step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
    @(posedge clk); #1; step = 1'b1;
    @(posedge clk); #1; step = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("ignored_step_dones", done_cnt - base, 1);
    chk("ignored_step_busy", int'(busy), 0);
    $display("protocol: step during RUN -> dones=%0d", done_cnt - base);

    // Step held high: back-to-back timesteps every N+2 cycles.
    base = done_cnt;
    @(posedge clk); #1; step = 1'b1;
    repeat (12) @(posedge clk);
    #1; step = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("held_step_dones", done_cnt - base, 2);
    chk("held_step_spacing", last_done - prev_done, N + 2);
    $display("protocol: held step -> dones=%0d spacing=%0d", done_cnt - base, last_done - prev_done);

    // Reset mid-RUN after a spiking step: everything cleared, no done.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    do_step(mk(255, 255, 255, 255, 4'b1111, 0, 0, 0, 0), "sat_all");
    @(posedge clk); #1; step = 1'b1; cur_in = 8'd60;
    @(posedge clk); #1; step = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrun_cur_idx", int'(cur_idx), 2);
    base = done_cnt;
    rst = 1'b1;
    #1;
    chk("midrun_rst_busy", int'(busy), 0);
    chk("midrun_rst_spike_vec", int'(spike_vec), 0);
    chk("midrun_rst_done", int'(done), 0);
    chk("midrun_rst_cur_idx", int'(cur_idx), 0);
    check_states("midrun_rst", '0);
    @(posedge clk); #1;
    rst = 1'b0; cur_in = '0;
    repeat (8) @(posedge clk);
    #1;
    chk("midrun_rst_no_done", done_cnt - base, 0);
    chk("midrun_rst_idle", int'(busy), 0);
    $display("protocol: reset mid-RUN -> dones=%0d busy=%0d", done_cnt - base, busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
